// File: rtl/scratchpad_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : scratchpad_pkg
//  Purpose  : Shared encodings for the scratchpad port arbiter: arbitration
//             mode selectors and the response-owner identifier.
//  Revision : 1.0 - initial release
// ============================================================================
package scratchpad_pkg;

  // Arbitration policy selectors for the ARB_MODE parameter
  localparam int ARB_BUS_PRIO = 0;  // bus wins, with a starvation guard for cpu_d
  localparam int ARB_RR       = 1;  // strict alternation on contention

  // Which requester owns the response currently in flight
  typedef enum logic {
    OWN_BUS   = 1'b0,
    OWN_CPU_D = 1'b1
  } owner_e;

endpackage
`default_nettype wire

// File: rtl/scratchpad_arb_core.sv
`default_nettype none
// ============================================================================
//  Module   : scratchpad_arb_core
//  Purpose  : Grant selection between the bus and cpu_d requesters. Holds the
//             cpu_d starvation counter and the last-granted record.
//  Revision : 1.0 - initial release
// ============================================================================
module scratchpad_arb_core
  import scratchpad_pkg::*;
#(
  parameter int ARB_MODE     = ARB_BUS_PRIO,
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,        // active-low, asynchronous
  input  logic bus_valid,
  input  logic cpu_d_valid,
  output logic grant_bus,
  output logic grant_cpu_d
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [3:0] r_starve;
  owner_e     r_last;
  logic       w_grant_bus;
  logic       w_grant_cpu_d;

  // Pick the winner for this cycle according to the configured policy
  always_comb begin
    w_grant_bus   = 1'b0;
    w_grant_cpu_d = 1'b0;
    if (ARB_MODE == ARB_RR) begin
      if (bus_valid && cpu_d_valid) begin
        w_grant_bus   = (r_last == OWN_CPU_D);
        w_grant_cpu_d = (r_last == OWN_BUS);
      end else begin
        w_grant_bus   = bus_valid;
        w_grant_cpu_d = cpu_d_valid;
      end
    end else begin
      w_grant_cpu_d = cpu_d_valid && (!bus_valid || (r_starve == c_starve_limit));
      w_grant_bus   = bus_valid && !w_grant_cpu_d;
    end
  end

  // Nothing is granted while reset is held, so no request can slip through
  assign grant_bus   = w_grant_bus   && reset;
  assign grant_cpu_d = w_grant_cpu_d && reset;

  // Track consecutive cpu_d denials (saturating) and the last accepted owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_starve <= 4'd0;
      r_last   <= OWN_CPU_D;  // bus wins the first round-robin contention
    end else begin
      if (cpu_d_valid && !grant_cpu_d) begin
        if (r_starve != c_starve_limit) begin
          r_starve <= r_starve + 4'd1;
        end
      end else begin
        r_starve <= 4'd0;
      end
      if (grant_cpu_d) begin
        r_last <= OWN_CPU_D;
      end else if (grant_bus) begin
        r_last <= OWN_BUS;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/scratchpad_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : scratchpad_port_arbiter
//  Purpose  : Shares one single-ported scratchpad between a bus requester and
//             the cpu data port. One accept per cycle, fixed 1-cycle response.
//  Revision : 1.0 - initial release
// ============================================================================
module scratchpad_port_arbiter
  import scratchpad_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int ARB_MODE     = ARB_BUS_PRIO,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // bus requester
  input  logic              bus_req_valid,
  output logic              bus_req_ready,
  input  logic [31:0]       bus_req_addr,
  input  logic              bus_req_wen,
  input  logic [3:0]        bus_req_wmask,
  input  logic [31:0]       bus_req_data,
  output logic              bus_resp_valid,
  output logic [31:0]       bus_resp_data,
  // cpu data-port requester
  input  logic              cpu_d_req_valid,
  output logic              cpu_d_req_ready,
  input  logic [31:0]       cpu_d_req_addr,
  input  logic              cpu_d_req_wen,
  input  logic [3:0]        cpu_d_req_wmask,
  input  logic [31:0]       cpu_d_req_data,
  input  logic              cpu_d_req_tag,
  output logic              cpu_d_resp_valid,
  output logic [31:0]       cpu_d_resp_data,
  output logic              cpu_d_resp_tag,
  // shared memory port
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  logic   w_grant_bus;
  logic   w_grant_cpu_d;
  logic   w_accept_bus;
  logic   w_accept_cpu_d;
  logic   w_unused_addr_bits;
  logic   r_resp_valid;
  owner_e r_resp_owner;
  logic   r_tag;

  scratchpad_arb_core #(
    .ARB_MODE     (ARB_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb_core (
    .clk         (clk),
    .reset       (reset),
    .bus_valid   (bus_req_valid),
    .cpu_d_valid (cpu_d_req_valid),
    .grant_bus   (w_grant_bus),
    .grant_cpu_d (w_grant_cpu_d)
  );

  assign bus_req_ready   = w_grant_bus;
  assign cpu_d_req_ready = w_grant_cpu_d;
  assign w_accept_bus    = bus_req_valid   && w_grant_bus;
  assign w_accept_cpu_d  = cpu_d_req_valid && w_grant_cpu_d;

  // Byte-offset bits and bits above the memory size are dropped (address wraps)
  assign w_unused_addr_bits = ^{bus_req_addr, cpu_d_req_addr};

  // Steer the accepted request onto the memory port; idle port drives zeros
  always_comb begin
    mem_en    = w_accept_bus || w_accept_cpu_d;
    mem_addr  = '0;
    mem_we    = 4'b0000;
    mem_wdata = 32'd0;
    if (w_accept_cpu_d) begin
      mem_addr  = cpu_d_req_addr[ADDR_W+1:2];
      mem_we    = cpu_d_req_wen ? cpu_d_req_wmask : 4'b0000;
      mem_wdata = cpu_d_req_data;
    end else if (w_accept_bus) begin
      mem_addr  = bus_req_addr[ADDR_W+1:2];
      mem_we    = bus_req_wen ? bus_req_wmask : 4'b0000;
      mem_wdata = bus_req_data;
    end
  end

  // Remember who was accepted so the response lands one cycle later
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_resp_valid <= 1'b0;
      r_resp_owner <= OWN_BUS;
      r_tag        <= 1'b0;
    end else begin
      r_resp_valid <= w_accept_bus || w_accept_cpu_d;
      r_resp_owner <= w_accept_cpu_d ? OWN_CPU_D : OWN_BUS;
      if (w_accept_cpu_d) begin
        r_tag <= cpu_d_req_tag;
      end
    end
  end

  assign bus_resp_valid   = r_resp_valid && (r_resp_owner == OWN_BUS);
  assign cpu_d_resp_valid = r_resp_valid && (r_resp_owner == OWN_CPU_D);
  assign bus_resp_data    = mem_rdata;
  assign cpu_d_resp_data  = mem_rdata;
  assign cpu_d_resp_tag   = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_scratchpad_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scratchpad_port_arbiter
//  Purpose  : Bench for scratchpad_port_arbiter. Instance 0 uses bus-priority
//             arbitration, instance 1 round-robin; both see the same stimulus
//             and each has its own memory and reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_scratchpad_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int LIMIT  = 4;

  logic clk = 1'b0;
  logic reset;

  logic        bus_valid, bus_wen, cpu_valid, cpu_wen, cpu_tag;
  logic [3:0]  bus_wmask, cpu_wmask;
  logic [31:0] bus_addr, bus_data, cpu_addr, cpu_data;

  logic [1:0]  bus_ready, cpu_ready, bus_rv, cpu_rv, cpu_rtag, mem_en;
  logic [31:0] bus_rdata [2];
  logic [31:0] cpu_rdata [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [ADDR_W-1:0] mem_addr [2];
  logic [3:0]  mem_we [2];

  logic [31:0] mem    [2][1024];
  logic [31:0] shadow [2][1024];

  int checks   = 0;
  int failures = 0;

  // reference model state
  int          starve   [2];
  bit          last_cpu [2];
  bit          pend_v   [2];
  bit          pend_cpu [2];
  logic [31:0] pend_data[2];
  bit          exp_tag  [2];

  always #5 clk = ~clk;

  scratchpad_port_arbiter #(.ADDR_W(ADDR_W), .ARB_MODE(0), .STARVE_LIMIT(LIMIT)) u_dut_prio (
    .clk(clk), .reset(reset),
    .bus_req_valid(bus_valid), .bus_req_ready(bus_ready[0]), .bus_req_addr(bus_addr),
    .bus_req_wen(bus_wen), .bus_req_wmask(bus_wmask), .bus_req_data(bus_data),
    .bus_resp_valid(bus_rv[0]), .bus_resp_data(bus_rdata[0]),
    .cpu_d_req_valid(cpu_valid), .cpu_d_req_ready(cpu_ready[0]), .cpu_d_req_addr(cpu_addr),
    .cpu_d_req_wen(cpu_wen), .cpu_d_req_wmask(cpu_wmask), .cpu_d_req_data(cpu_data),
    .cpu_d_req_tag(cpu_tag), .cpu_d_resp_valid(cpu_rv[0]), .cpu_d_resp_data(cpu_rdata[0]),
    .cpu_d_resp_tag(cpu_rtag[0]),
    .mem_en(mem_en[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  scratchpad_port_arbiter #(.ADDR_W(ADDR_W), .ARB_MODE(1), .STARVE_LIMIT(LIMIT)) u_dut_rr (
    .clk(clk), .reset(reset),
    .bus_req_valid(bus_valid), .bus_req_ready(bus_ready[1]), .bus_req_addr(bus_addr),
    .bus_req_wen(bus_wen), .bus_req_wmask(bus_wmask), .bus_req_data(bus_data),
    .bus_resp_valid(bus_rv[1]), .bus_resp_data(bus_rdata[1]),
    .cpu_d_req_valid(cpu_valid), .cpu_d_req_ready(cpu_ready[1]), .cpu_d_req_addr(cpu_addr),
    .cpu_d_req_wen(cpu_wen), .cpu_d_req_wmask(cpu_wmask), .cpu_d_req_data(cpu_data),
    .cpu_d_req_tag(cpu_tag), .cpu_d_resp_valid(cpu_rv[1]), .cpu_d_resp_data(cpu_rdata[1]),
    .cpu_d_resp_tag(cpu_rtag[1]),
    .mem_en(mem_en[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  // Memory behind each arbiter: read-before-write, data valid next cycle
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d]) begin
        mem_rdata[d] <= mem[d][mem_addr[d]];
        for (int b = 0; b < 4; b++) begin
          if (mem_we[d][b]) mem[d][mem_addr[d]][8*b +: 8] <= mem_wdata[d][8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, d, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      starve[d] = 0; last_cpu[d] = 1'b1; pend_v[d] = 1'b0;
      pend_cpu[d] = 1'b0; exp_tag[d] = 1'b0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      chk({tag, "_bus_ready"}, d, 32'(bus_ready[d]), 32'd0);
      chk({tag, "_cpu_ready"}, d, 32'(cpu_ready[d]), 32'd0);
      chk({tag, "_bus_rv"},    d, 32'(bus_rv[d]),    32'd0);
      chk({tag, "_cpu_rv"},    d, 32'(cpu_rv[d]),    32'd0);
      chk({tag, "_tag"},       d, 32'(cpu_rtag[d]),  32'd0);
      chk({tag, "_mem_en"},    d, 32'(mem_en[d]),    32'd0);
      chk({tag, "_mem_we"},    d, 32'(mem_we[d]),    32'd0);
    end
  endtask

  // One clock of checking against the model; inputs driven just after posedge
  task automatic step();
    bit gb, gc;
    logic [31:0] a_full, wd;
    logic [3:0]  we;
    int a;
    #3;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        gc = cpu_valid && (!bus_valid || starve[d] == LIMIT);
        gb = bus_valid && !gc;
      end else if (bus_valid && cpu_valid) begin
        gb = last_cpu[d]; gc = !gb;
      end else begin
        gb = bus_valid; gc = cpu_valid;
      end
      a_full = gc ? cpu_addr : (gb ? bus_addr : 32'd0);
      a      = int'(a_full[ADDR_W+1:2]);
      wd     = gc ? cpu_data : (gb ? bus_data : 32'd0);
      we     = gc ? (cpu_wen ? cpu_wmask : 4'b0) : (gb ? (bus_wen ? bus_wmask : 4'b0) : 4'b0);
      chk("bus_ready", d, 32'(bus_ready[d]), 32'(gb));
      chk("cpu_ready", d, 32'(cpu_ready[d]), 32'(gc));
      chk("mem_en",    d, 32'(mem_en[d]),    32'(gb | gc));
      chk("mem_addr",  d, 32'(mem_addr[d]),  32'(a));
      chk("mem_we",    d, 32'(mem_we[d]),    32'(we));
      chk("mem_wdata", d, mem_wdata[d],      wd);
      chk("bus_rv",    d, 32'(bus_rv[d]),    32'(pend_v[d] && !pend_cpu[d]));
      chk("cpu_rv",    d, 32'(cpu_rv[d]),    32'(pend_v[d] && pend_cpu[d]));
      chk("cpu_tag",   d, 32'(cpu_rtag[d]),  32'(exp_tag[d]));
      if (pend_v[d]) begin
        chk("resp_data", d, pend_cpu[d] ? cpu_rdata[d] : bus_rdata[d], pend_data[d]);
      end
      // advance the model to the next cycle
      pend_v[d]   = gb | gc;
      pend_cpu[d] = gc;
      if (gb | gc) begin
        pend_data[d] = shadow[d][a];
        for (int b = 0; b < 4; b++) if (we[b]) shadow[d][a][8*b +: 8] = wd[8*b +: 8];
        last_cpu[d] = gc;
      end
      if (gc) exp_tag[d] = cpu_tag;
      if (cpu_valid && !gc) starve[d] = (starve[d] < LIMIT) ? starve[d] + 1 : LIMIT;
      else starve[d] = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    bus_valid = 0; bus_wen = 0; bus_wmask = 0; bus_addr = 0; bus_data = 0;
    cpu_valid = 0; cpu_wen = 0; cpu_wmask = 0; cpu_addr = 0; cpu_data = 0; cpu_tag = 0;
  endtask

  task automatic pulse_reset();
    #3 reset = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      for (int d = 0; d < 2; d++) begin
        mem[d][i]    = 32'(i) * 32'h9E3779B1;
        shadow[d][i] = 32'(i) * 32'h9E3779B1;
      end
    end
    for (int d = 0; d < 2; d++) begin
      mem[d][4] = 32'hDEADBEEF; shadow[d][4] = 32'hDEADBEEF;
      mem_rdata[d] = 32'd0;
    end
    idle_inputs();
    bus_valid = 1; cpu_valid = 1; bus_wen = 1; bus_wmask = 4'hF;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2 chk_reset_outputs("por");
    idle_inputs();
    #1 reset = 1'b1;
    model_reset();
    @(posedge clk); #1;

    // single cpu_d read of word 4 with tag 1
    cpu_valid = 1; cpu_addr = 32'h10; cpu_tag = 1;
    step();
    idle_inputs();
    for (int d = 0; d < 2; d++) begin
      chk("rd_cpu_rv",   d, 32'(cpu_rv[d]),  32'd1);
      chk("rd_cpu_data", d, cpu_rdata[d],    32'hDEADBEEF);
      chk("rd_cpu_tag",  d, 32'(cpu_rtag[d]), 32'd1);
      chk("rd_bus_rv",   d, 32'(bus_rv[d]),  32'd0);
    end
    step();

    // bus write, partial mask
    bus_valid = 1; bus_wen = 1; bus_addr = 32'h8; bus_wmask = 4'b0101; bus_data = 32'h11223344;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("wr_mem_we",   d, 32'(mem_we[d]),   32'h5);
      chk("wr_mem_addr", d, 32'(mem_addr[d]), 32'd2);
    end
    step();
    idle_inputs();
    for (int d = 0; d < 2; d++) chk("wr_bus_rv", d, 32'(bus_rv[d]), 32'd1);
    step();

    // continuous contention from reset: starvation pattern / alternation
    pulse_reset();
    for (int i = 0; i < 15; i++) begin
      bus_valid = 1; cpu_valid = 1;
      bus_addr = $urandom; cpu_addr = $urandom; bus_data = $urandom; cpu_data = $urandom;
      bus_wen = 1'($urandom); cpu_wen = 1'($urandom);
      bus_wmask = 4'($urandom); cpu_wmask = 4'($urandom); cpu_tag = 1'($urandom);
      #1;
      chk("prio_pattern", 0, 32'(cpu_ready[0]), 32'((i % 5) == 4));
      chk("rr_pattern",   1, 32'(cpu_ready[1]), 32'((i % 2) == 1));
      step();
    end

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      bus_valid = ($urandom_range(0, 3) != 0); cpu_valid = ($urandom_range(0, 2) != 0);
      bus_addr = $urandom; cpu_addr = $urandom; bus_data = $urandom; cpu_data = $urandom;
      bus_wen = 1'($urandom); cpu_wen = 1'($urandom);
      bus_wmask = 4'($urandom); cpu_wmask = 4'($urandom); cpu_tag = 1'($urandom);
      step();
    end

    // reset the cycle after an accept: the response must vanish
    idle_inputs();
    cpu_valid = 1; cpu_addr = 32'h24; cpu_tag = 1; bus_valid = 1; bus_addr = 32'h30;
    step();
    reset = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    model_reset();
    @(posedge clk); #1;
    chk_reset_outputs("mid_rst_hold");
    idle_inputs();
    #3 reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/scratchpad_port_arbiter.md
SCRATCHPAD_PORT_ARBITER -- requirements
Module: scratchpad_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width of the shared memory port (1024 words).
REQ-002 SHALL have parameter ARB_MODE, default 0: 0 = bus-priority with starvation guard, 1 = strict round-robin.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, range 1..15: consecutive denied cpu_d cycles before forced cpu_d grant.
REQ-004 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports bus_req_valid in 1; bus_req_ready out 1; bus_req_addr in 32; bus_req_wen in 1; bus_req_wmask in 4; bus_req_data in 32: bus requester.
REQ-007 SHALL have ports bus_resp_valid out 1; bus_resp_data out 32: bus response.
REQ-008 SHALL have ports cpu_d_req_valid in 1; cpu_d_req_ready out 1; cpu_d_req_addr in 32; cpu_d_req_wen in 1; cpu_d_req_wmask in 4; cpu_d_req_data in 32; cpu_d_req_tag in 1: data-port requester.
REQ-009 SHALL have ports cpu_d_resp_valid out 1; cpu_d_resp_data out 32; cpu_d_resp_tag out 1: data-port response.
REQ-010 SHALL have ports mem_en out 1; mem_addr out ADDR_W; mem_we out 4; mem_wdata out 32; mem_rdata in 32: shared memory port, always ready, read data valid the cycle after mem_en.

Function
REQ-011 SHALL accept a request when valid && ready (same cycle); at most one requester ready per cycle.
REQ-012 SHALL drive ready combinationally from grant; ready SHALL NOT depend on the requester's own valid beyond arbitration.
REQ-013 SHALL, ARB_MODE=0: grant bus when bus_req_valid, unless starve counter == STARVE_LIMIT and cpu_d_req_valid, then grant cpu_d.
REQ-014 SHALL keep starve counter (4 bits): increment when cpu_d_req_valid && !cpu_d granted, saturate at STARVE_LIMIT; clear on cpu_d grant or cpu_d_req_valid low.
REQ-015 SHALL, ARB_MODE=1: on contention grant requester not granted last; single valid requester always granted; last-grant register updates only on accept.
REQ-016 SHALL drive mem_en = accept; mem_addr = granted addr[ADDR_W+1:2]; mem_we = wen ? wmask : 4'b0; mem_wdata = granted data; mem_addr/mem_wdata SHALL be 0 when idle.
REQ-017 SHALL register response owner, and cpu_d tag, at accept; exactly one cycle later assert owner's resp_valid for one cycle, reads and writes alike.
REQ-018 SHALL route mem_rdata to both resp_data outputs combinationally; only resp_valid selects ownership.
REQ-019 SHALL sustain one accept per cycle (back-to-back), response latency fixed at 1 cycle, no response reordering.
REQ-020 SHALL hold cpu_d_resp_tag stable until the next cpu_d accept response.
REQ-021 SHALL ignore addr bits [1:0] and bits above ADDR_W+1 (wrap within memory).

Reset
REQ-022 SHALL on reset assertion immediately clear starve counter, last-grant (= cpu_d, so bus wins first RR contention), owner-valid pipeline, tag.
REQ-023 SHALL hold bus_resp_valid, cpu_d_resp_valid, cpu_d_resp_tag, mem_en, mem_we at 0 while reset asserted; ready outputs 0 while reset asserted.
REQ-024 SHALL drop any in-flight response when reset asserts mid-operation; no response after deassertion for pre-reset accepts.

Structure
REQ-025 SHALL place ARB_MODE encodings (ARB_BUS_PRIO=0, ARB_RR=1) and owner encoding (OWN_BUS, OWN_CPU_D) in shared package scratchpad_pkg.
REQ-026 SHALL isolate grant logic (mode, starve counter, last-grant) in one sub-module scratchpad_arb_core; datapath mux and response pipeline in top.

Verification
REQ-027 SHALL test: single cpu_d read addr 0x10, mem word 4 = 0xDEADBEEF, tag=1 -> cycle+1 cpu_d_resp_valid=1, data 0xDEADBEEF, tag 1, bus_resp_valid=0.
REQ-028 SHALL test: ARB_MODE=0, STARVE_LIMIT=4, both valid continuously -> bus granted 4 cycles, cpu_d 5th, pattern repeats.
REQ-029 SHALL test: ARB_MODE=1, both valid continuously from reset -> grants alternate bus, cpu_d, bus, ...; responses alternate one cycle later.
REQ-030 SHALL test: bus write addr 0x8 wmask 0b0101 data 0x11223344 -> mem_we=0b0101, mem_addr=2, bus_resp_valid next cycle.
REQ-031 SHALL test: reset asserted the cycle after an accept -> no resp_valid ever seen for that request; all outputs 0 during reset.
